spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI mode-0 slave (CPOL=0, CPHA=0) that receives MSB-first bytes on mosi and presents each completed byte on a parallel output. sck, mosi and cs are oversampled by the system clock, so clk must run at least 2x the sck rate. It also echoes the last received byte back on miso, MSB first. It sits between an off-block SPI master and on-chip logic that consumes data_out.

Parameters:
- DATA_W, 8, frame length in bits; also the width of data_out and of both shift registers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mosi  in  1  serial data from the master; sampled on detected sck rising edges.
- sck  in  1  SPI clock from the master; idles low.
- cs  in  1  active-low chip select.
- miso  out  1  serial data to the master, MSB first.
- data_out  out  DATA_W  last fully received frame.

Behaviour:
- Input timing: sck, mosi and cs are synchronous to clk (the master runs in the clk domain or synchronises them upstream). There are no internal synchronisers.
- Edge detection:
  - sck_d is one register holding the previous-cycle sck.
  - rise = sck & ~sck_d; fall = ~sck & sck_d. Both are combinational, one-clk pulses.
- Reset (rst=1 at a clk edge), overriding everything else:
  - data_out=0, rx_shift=0, tx_shift=0, bit_cnt=0, sck_d=0, miso=0.
- cs high (deselected):
  - bit_cnt cleared to 0; rx_shift is held.
  - tx_shift loaded with data_out; miso driven 0.
  - data_out retains its value.
- cs low, rise asserted:
  - rx_shift <= {rx_shift[DATA_W-2:0], mosi}, sampling mosi at the same clk edge.
  - bit_cnt increments.
  - On the DATA_W-th rise (bit_cnt==DATA_W-1): data_out <= {rx_shift[DATA_W-2:0], mosi} on that same clk edge, so latency is 0 cycles after rise detection. bit_cnt then wraps to 0.
- cs low, fall asserted:
  - If bit_cnt==0 (frame just completed): tx_shift <= data_out.
  - Otherwise: tx_shift shifts left by one, filling with 0.
- miso: equals tx_shift[DATA_W-1] while cs is low; 0 while cs is high.
- Back-to-back frames: no gap is required between frames beyond a single sck period; bit_cnt wrap handles continuous framing.
- cs rising mid-frame: the partial frame is discarded (bit_cnt=0) and data_out is unchanged.
- rise and fall cannot coincide by construction.
- sck toggling while cs is high is ignored, apart from keeping sck_d updated.
- No ready/valid handshake: data_out is a level that holds until the next completed frame.

Decomposition:
- No shared package needed. DATA_W is a module parameter; the bit-counter width is $clog2(DATA_W).
- One natural sub-module: spi_edge_detect (input sck, outputs rise and fall, contains sck_d).

Test Plan:
- Reset: hold rst=1 for 10 clk with cs=1, sck=0 -> data_out==8'h00, miso==0.
- Single frame: rst=0, cs=0; send 8'hAA MSB first with mosi set before each sck high (sck high 1 clk, low 1 clk); check 1 clk after the last sck fall -> data_out==8'hAA.
- Sequence with 1-clk gaps between frames: 8'h33, 8'h0F, 8'hFF, 8'h55, 8'h77, 8'hCC, 8'h11, 8'h99, 8'h66, 8'hFF -> data_out equals each byte after its frame; intermediate bits never update data_out.
- Echo: after receiving 8'hA5, clock a second frame -> miso bits sampled on sck rises read 1,0,1,0,0,1,0,1.
- Abort: cs=0, send 4 bits, raise cs, lower cs, send 8'h3C -> data_out==8'h3C; previous data_out unchanged during the aborted frame.
- Mid-frame reset: assert rst after 5 bits -> data_out==0 next clk; a following full 8'hC3 frame is received correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI mode-0 slave.
package spi_slave_pkg;
  localparam int SPI_DATA_W_DEF = 8;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the parallel received-frame output.
interface spi_slave_if #(
  parameter int DATA_W = spi_slave_pkg::SPI_DATA_W_DEF
);
  logic              mosi;
  logic              sck;
  logic              cs;
  logic              miso;
  logic [DATA_W-1:0] data_out;

  modport slave  (input mosi, sck, cs, output miso, data_out);
  modport master (output mosi, sck, cs, input miso, data_out);
endinterface

// File: rtl/spi_slave_edge_detect.sv
// One-cycle rise/fall pulses of sck, which is already in the clk domain.
module spi_slave_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  output logic rise,
  output logic fall
);
  logic sck_prev_q, sck_prev_d;

  always_comb sck_prev_d = sck;

  always_ff @(posedge clk) begin
    if (rst) sck_prev_q <= 1'b0;
    else     sck_prev_q <= sck_prev_d;
  end

  assign rise = sck & ~sck_prev_q;
  assign fall = ~sck & sck_prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: MSB-first receive into data_out, echo of last frame on miso.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_if.slave     bus
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic rise, fall;

  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  spi_slave_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .sck  (bus.sck),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    rx_d   = rx_q;
    tx_d   = tx_q;
    dout_d = dout_q;
    cnt_d  = cnt_q;
    if (bus.cs) begin
      // Deselected: drop any partial frame and pre-load the echo.
      cnt_d = '0;
      tx_d  = dout_q;
    end else if (rise) begin
      rx_d = {rx_q[DATA_W-2:0], bus.mosi};
      if (cnt_q == LAST_BIT) begin
        cnt_d  = '0;
        dout_d = {rx_q[DATA_W-2:0], bus.mosi};
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (fall) begin
      // cnt==0 on a fall means a frame just finished: start echoing it.
      if (cnt_q == '0) tx_d = dout_q;
      else             tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q   <= '0;
      tx_q   <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.miso     = bus.cs ? 1'b0 : tx_q[DATA_W-1];
  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed + randomized bench for spi_slave with a frame-level reference model.
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_dout;

  spi_slave_if #(.DATA_W(8)) bus ();

  spi_slave #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send nbits of b MSB first; miso must echo the last completed frame.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    logic [7:0] echo;
    echo = exp_dout;
    for (int i = 0; i < nbits; i++) begin
      tick();
      bus.mosi = b[7-i];
      bus.sck  = 1'b1;
      chk("echo_bit", {31'b0, bus.miso}, {31'b0, echo[7-i]});
      if (i == nbits - 1 && nbits == 8)
        chk("no_early_update", {24'b0, bus.data_out}, {24'b0, exp_dout});
      tick();
      bus.sck = 1'b0;
    end
    tick();
    if (nbits == 8) exp_dout = b;
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    send_bits(b, 8);
    tick();
    chk(tag, {24'b0, bus.data_out}, {24'b0, exp_dout});
  endtask

  initial begin
    logic [7:0] seq [10];
    logic [7:0] r;
    int n;
    seq = '{8'h33, 8'h0F, 8'hFF, 8'h55, 8'h77, 8'hCC, 8'h11, 8'h99, 8'h66, 8'hFF};
    exp_dout = 8'h00;
    rst = 1'b1; bus.cs = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
    repeat (10) tick();
    chk("reset_dout", {24'b0, bus.data_out}, 32'h0);
    chk("reset_miso", {31'b0, bus.miso}, 32'h0);
    rst = 1'b0;
    tick();
    bus.cs = 1'b0;

    send_byte(8'hAA, "single_AA");

    foreach (seq[i]) begin
      tick();
      send_byte(seq[i], "seq_frame");
    end

    send_byte(8'hA5, "echo_src");
    send_byte(8'h00, "echo_frame");

    // Aborted frame: partial bits must not disturb data_out.
    send_bits(8'hF0, 4);
    bus.cs = 1'b1;
    tick();
    chk("abort_hold", {24'b0, bus.data_out}, {24'b0, exp_dout});
    tick();
    bus.cs = 1'b0;
    send_byte(8'h3C, "after_abort");

    // Reset in the middle of a frame.
    send_bits(8'h5A, 5);
    rst = 1'b1;
    tick();
    chk("midreset_dout", {24'b0, bus.data_out}, 32'h0);
    rst = 1'b0;
    exp_dout = 8'h00;
    send_byte(8'hC3, "after_reset");

    // Random frames, gaps and aborts.
    for (int k = 0; k < 40; k++) begin
      r = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(1, 7);
          send_bits(r, n);
          bus.cs = 1'b1;
          repeat ($urandom_range(1, 3)) tick();
          chk("rand_abort", {24'b0, bus.data_out}, {24'b0, exp_dout});
          bus.cs = 1'b0;
        end
        1: begin
          repeat ($urandom_range(1, 3)) tick();
          send_byte(r, "rand_gap");
        end
        default: send_byte(r, "rand_b2b");
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
